// File: rtl/dm_arbiter.sv
// dm_arbiter
//   Shares one synchronous (1-cycle read latency) data memory between
//   NUM_REQ cores. Round-robin arbitration issues at most one access per
//   cycle. Read data is returned to the core that was granted, and the
//   cores' end_process flags are combined into one sticky all_done.
//
// Ports
//   clk        system clock, rising edge
//   rst_n      synchronous active-low reset
//   req        per-core request, held until the grant is seen
//   we         per-core write enable (1 = write, 0 = read)
//   addr       per-core address, core i at [i*ADDR_W +: ADDR_W]
//   wdata      per-core write data, core i at [i*DATA_W +: DATA_W]
//   done_in    per-core end_process
//   gnt        one-hot grant pulse (registered)
//   rvalid     one-hot read-data-valid pulse (registered)
//   rdata      read data broadcast, a pass-through of mem_rdata
//   mem_we     registered memory write enable
//   mem_addr   registered memory address
//   mem_wdata  registered memory write data
//   mem_rdata  memory read data, valid the cycle after mem_addr
//   all_done   sticky, high once every done_in bit has been seen
module dm_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ADDR_W  = 12,
  parameter int unsigned DATA_W  = 12
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        we,
  input  logic [NUM_REQ*ADDR_W-1:0] addr,
  input  logic [NUM_REQ*DATA_W-1:0] wdata,
  input  logic [NUM_REQ-1:0]        done_in,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        rvalid,
  output logic [DATA_W-1:0]         rdata,
  output logic                      mem_we,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  input  logic [DATA_W-1:0]         mem_rdata,
  output logic                      all_done
);

  localparam int unsigned PTR_W = $clog2(NUM_REQ);

  // Registered state
  logic [PTR_W-1:0]   r_ptr;
  logic [NUM_REQ-1:0] r_gnt;
  logic [NUM_REQ-1:0] r_rvalid;
  logic               r_mem_we;
  logic [ADDR_W-1:0]  r_mem_addr;
  logic [DATA_W-1:0]  r_mem_wdata;
  logic [NUM_REQ-1:0] r_seen;
  logic               r_all_done;

  // Arbitration datapath
  logic [NUM_REQ-1:0] w_elig;
  logic [NUM_REQ-1:0] w_rot;
  logic [NUM_REQ-1:0] w_oh_rot;
  logic [NUM_REQ-1:0] w_gnt_nxt;
  logic               w_any;
  logic               w_sel_we;
  logic [ADDR_W-1:0]  w_sel_addr;
  logic [DATA_W-1:0]  w_sel_wdata;
  logic [PTR_W-1:0]   w_ptr_nxt;
  logic [NUM_REQ-1:0] w_seen_nxt;

  // A core that is being granted this cycle still holds req; masking it
  // with the current grant prevents a second grant for the same access.
  assign w_elig = req & ~r_gnt;
  assign w_any  = |w_elig;

  // Rotate eligibility so the pointer position becomes bit 0; a plain
  // lowest-set-bit pick then implements the wrapping round-robin search.
  assign w_rot = NUM_REQ'({w_elig, w_elig} >> r_ptr);

  always_comb begin
    logic v_found;
    v_found  = 1'b0;
    w_oh_rot = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (w_rot[k] && !v_found) begin
        w_oh_rot[k] = 1'b1;
        v_found     = 1'b1;
      end
    end
  end

  // Rotate the one-hot pick back into core-index space.
  assign w_gnt_nxt = NUM_REQ'(({w_oh_rot, w_oh_rot} << r_ptr) >> NUM_REQ);

  // AND-OR select of the winning core's access fields and next pointer.
  always_comb begin
    w_sel_we    = 1'b0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    w_ptr_nxt   = r_ptr;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (w_gnt_nxt[i]) begin
        w_sel_we    = we[i];
        w_sel_addr  = addr[i*ADDR_W +: ADDR_W];
        w_sel_wdata = wdata[i*DATA_W +: DATA_W];
        w_ptr_nxt   = PTR_W'((i + 1) % NUM_REQ);
      end
    end
  end

  // all_done follows the updated mask, so the last done pulse sets it at
  // the same edge that records it.
  assign w_seen_nxt = r_seen | done_in;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr       <= '0;
      r_gnt       <= '0;
      r_rvalid    <= '0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_seen      <= '0;
      r_all_done  <= 1'b0;
    end else begin
      r_gnt    <= w_gnt_nxt;
      r_mem_we <= w_sel_we;
      // A read granted last cycle has its data on mem_rdata this cycle.
      r_rvalid <= r_gnt & {NUM_REQ{~r_mem_we}};
      if (w_any) begin
        r_mem_addr  <= w_sel_addr;
        r_mem_wdata <= w_sel_wdata;
        r_ptr       <= w_ptr_nxt;
      end
      r_seen <= w_seen_nxt;
      if (&w_seen_nxt) begin
        r_all_done <= 1'b1;
      end
    end
  end

  assign gnt       = r_gnt;
  assign rvalid    = r_rvalid;
  assign rdata     = mem_rdata;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign all_done  = r_all_done;

endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter
//   Directed bench for dm_arbiter: a 2-core instance backed by a small
//   behavioural data memory, plus a 4-core instance for pointer wrap-around.
//   Expected outputs are queued when stimulus is driven and compared after
//   the next rising edge.
module tb_dm_arbiter;

  localparam int unsigned AW = 12;
  localparam int unsigned DW = 12;

  localparam int unsigned S_GNT    = 0;
  localparam int unsigned S_RVALID = 1;
  localparam int unsigned S_RDATA  = 2;
  localparam int unsigned S_MWE    = 3;
  localparam int unsigned S_MADDR  = 4;
  localparam int unsigned S_MWDATA = 5;
  localparam int unsigned S_DONE   = 6;
  localparam int unsigned S_GNT4   = 7;
  localparam int unsigned S_MADDR4 = 8;
  localparam int unsigned S_RVAL4  = 9;

  logic clk = 1'b0;
  logic rst_n;

  // 2-core instance
  logic [1:0]    req, we, done_in, gnt, rvalid;
  logic [2*AW-1:0] addr;
  logic [2*DW-1:0] wdata;
  logic [DW-1:0] rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_we, all_done;

  // 4-core instance
  logic [3:0]    req4, we4, done4, gnt4, rvalid4;
  logic [4*AW-1:0] addr4;
  logic [4*DW-1:0] wdata4;
  logic [DW-1:0] rdata4, mem_wdata4, mem_rdata4;
  logic [AW-1:0] mem_addr4;
  logic          mem_we4, all_done4;

  logic [DW-1:0] mem [0:4095];

  typedef struct {
    string       tag;
    int unsigned sig;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  dm_arbiter #(.NUM_REQ(2), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .done_in(done_in), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .all_done(all_done)
  );

  dm_arbiter #(.NUM_REQ(4), .ADDR_W(AW), .DATA_W(DW)) dut4 (
    .clk(clk), .rst_n(rst_n), .req(req4), .we(we4), .addr(addr4), .wdata(wdata4),
    .done_in(done4), .gnt(gnt4), .rvalid(rvalid4), .rdata(rdata4),
    .mem_we(mem_we4), .mem_addr(mem_addr4), .mem_wdata(mem_wdata4),
    .mem_rdata(mem_rdata4), .all_done(all_done4)
  );

  // Synchronous 1-cycle-read data memory (read-before-write).
  always @(posedge clk) begin
    mem_rdata <= mem[mem_addr];
    if (mem_we) mem[mem_addr] = mem_wdata;
  end

  function automatic logic [31:0] obs(int unsigned sig);
    case (sig)
      S_GNT:    return 32'(gnt);
      S_RVALID: return 32'(rvalid);
      S_RDATA:  return 32'(rdata);
      S_MWE:    return 32'(mem_we);
      S_MADDR:  return 32'(mem_addr);
      S_MWDATA: return 32'(mem_wdata);
      S_DONE:   return 32'(all_done);
      S_GNT4:   return 32'(gnt4);
      S_MADDR4: return 32'(mem_addr4);
      S_RVAL4:  return 32'(rvalid4);
      default:  return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic expect_v(input string tag, input int unsigned sig, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.sig = sig;
    e.exp = v;
    sb.push_back(e);
  endtask

  // Advance one clock and check everything queued for this edge.
  task automatic tick();
    exp_t e;
    logic [31:0] o;
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = obs(e.sig);
      vectors++;
      assert (o === e.exp) else begin
        miscompares++;
        $error("FAIL %s: observed 0x%0h expected 0x%0h", e.tag, o, e.exp);
      end
    end
  endtask

  task automatic idle_inputs();
    req = '0; we = '0; addr = '0; wdata = '0; done_in = '0;
    req4 = '0; we4 = '0; addr4 = '0; wdata4 = '0; done4 = '0;
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    idle_inputs();
    expect_v({tag, "_gnt"},    S_GNT,    0);
    expect_v({tag, "_rvalid"}, S_RVALID, 0);
    expect_v({tag, "_mwe"},    S_MWE,    0);
    expect_v({tag, "_maddr"},  S_MADDR,  0);
    expect_v({tag, "_mwdata"}, S_MWDATA, 0);
    expect_v({tag, "_done"},   S_DONE,   0);
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0] g, prev;
    for (int i = 0; i < 4096; i++) mem[i] = '0;
    mem[12'h005] = 12'h0A5;
    mem[12'h011] = 12'h3C7;
    mem_rdata4 = '0;
    rst_n = 1'b0;
    idle_inputs();
    tick();

    // Reset then single read from core 0
    do_reset("rst");
    req = 2'b01; we = 2'b00; addr[11:0] = 12'h005;
    expect_v("rd_gnt", S_GNT, 2'b01);
    expect_v("rd_maddr", S_MADDR, 12'h005);
    expect_v("rd_mwe", S_MWE, 0);
    tick();
    expect_v("rd_mask_gnt", S_GNT, 0);
    expect_v("rd_rvalid", S_RVALID, 2'b01);
    expect_v("rd_rdata", S_RDATA, 12'h0A5);
    tick();
    req = 2'b00;
    expect_v("rd_idle_rvalid", S_RVALID, 0);
    tick();

    // Contention: core0 writes, core1 reads
    do_reset("rst2");
    req = 2'b11; we = 2'b01;
    addr = {12'h011, 12'h010}; wdata = {12'h000, 12'h123};
    expect_v("ct_gnt0", S_GNT, 2'b01);
    expect_v("ct_mwe0", S_MWE, 1);
    expect_v("ct_maddr0", S_MADDR, 12'h010);
    expect_v("ct_mwdata0", S_MWDATA, 12'h123);
    tick();
    expect_v("ct_gnt1", S_GNT, 2'b10);
    expect_v("ct_mwe1", S_MWE, 0);
    expect_v("ct_maddr1", S_MADDR, 12'h011);
    expect_v("ct_wr_norvalid", S_RVALID, 0);
    tick();
    req = 2'b10;
    expect_v("ct_idle_gnt", S_GNT, 0);
    expect_v("ct_rvalid1", S_RVALID, 2'b10);
    expect_v("ct_rdata1", S_RDATA, 12'h3C7);
    expect_v("ct_hold_maddr", S_MADDR, 12'h011);
    tick();
    // Pointer back at 0: core0 wins, then read back core0's write via core1
    req = 2'b11; we = 2'b00; addr = {12'h010, 12'h005};
    expect_v("ptr0_gnt", S_GNT, 2'b01);
    tick();
    expect_v("ptr0_gnt1", S_GNT, 2'b10);
    expect_v("ptr0_rvalid0", S_RVALID, 2'b01);
    expect_v("ptr0_rdata0", S_RDATA, 12'h0A5);
    tick();
    req = 2'b10;
    expect_v("wb_gnt", S_GNT, 0);
    expect_v("wb_rvalid", S_RVALID, 2'b10);
    expect_v("wb_rdata", S_RDATA, 12'h123);
    tick();
    req = 2'b00;
    tick();

    // Fairness: both cores request continuously -> strict alternation
    req = 2'b11; we = 2'b00;
    g = 2'b01; prev = 2'b00;
    for (int n = 0; n < 8; n++) begin
      expect_v("fair_gnt", S_GNT, 32'(g));
      expect_v("fair_rvalid", S_RVALID, 32'(prev));
      tick();
      prev = g;
      g = (g == 2'b01) ? 2'b10 : 2'b01;
    end
    req = 2'b00;
    expect_v("fair_end_gnt", S_GNT, 0);
    expect_v("fair_end_rvalid", S_RVALID, 2'b10);
    tick();

    // Single continuous requester: granted every other cycle
    req = 2'b01;
    for (int n = 0; n < 4; n++) begin
      expect_v("solo_gnt", S_GNT, (n % 2 == 0) ? 32'd1 : 32'd0);
      tick();
    end
    req = 2'b00;
    tick();
    tick();

    // Reset mid-read: no rvalid afterwards, pointer back at core 0
    do_reset("rst3");
    req = 2'b10; addr = {12'h005, 12'h000};
    expect_v("mr_gnt", S_GNT, 2'b10);
    tick();
    do_reset("mr_rst");
    req = 2'b11;
    expect_v("mr_after_rvalid", S_RVALID, 0);
    expect_v("mr_after_gnt", S_GNT, 2'b01);
    tick();
    req = 2'b00;
    tick();

    // Done aggregation with non-overlapping pulses
    done_in = 2'b01;
    expect_v("dn_first", S_DONE, 0);
    tick();
    done_in = 2'b00;
    for (int n = 0; n < 3; n++) begin
      expect_v("dn_wait", S_DONE, 0);
      tick();
    end
    done_in = 2'b10;
    expect_v("dn_set", S_DONE, 1);
    tick();
    done_in = 2'b00;
    expect_v("dn_sticky", S_DONE, 1);
    tick();
    do_reset("dn_rst");
    expect_v("dn_cleared", S_DONE, 0);
    tick();

    // Wrap-around on the 4-core instance
    addr4 = {12'h333, 12'h222, 12'h111, 12'h100};
    req4 = 4'b0100;
    expect_v("w4_gnt2", S_GNT4, 4'b0100);
    tick();
    req4 = 4'b1001;
    expect_v("w4_gnt3", S_GNT4, 4'b1000);
    expect_v("w4_addr3", S_MADDR4, 12'h333);
    tick();
    expect_v("w4_gnt0", S_GNT4, 4'b0001);
    expect_v("w4_addr0", S_MADDR4, 12'h100);
    expect_v("w4_rval3", S_RVAL4, 4'b1000);
    tick();
    req4 = 4'b0000;
    expect_v("w4_idle", S_GNT4, 0);
    tick();
    req4 = 4'b1011;
    expect_v("w4_ptr1", S_GNT4, 4'b0010);
    tick();
    expect_v("w4_next3", S_GNT4, 4'b1000);
    tick();
    expect_v("w4_next0", S_GNT4, 4'b0001);
    tick();
    expect_v("w4_next1", S_GNT4, 4'b0010);
    tick();
    req4 = 4'b0000;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
